// File: rtl/seq_multiplier_if.sv
// Handshake and operand bundle for the sequential shift-add multiply-accumulate unit.
// The master starts operations; the slave (the multiplier) reports busy/done and the product.
interface seq_multiplier_if #(
    parameter int D_WIDTH = 4
);
    logic                   i_start;
    logic [D_WIDTH-1:0]     i_multiplicand;
    logic [D_WIDTH-1:0]     i_multiplier;
    logic [D_WIDTH-1:0]     i_addend;
    logic                   o_busy;
    logic                   o_done;
    logic [2*D_WIDTH-1:0]   o_product;

    modport master (
        output i_start, i_multiplicand, i_multiplier, i_addend,
        input  o_busy, o_done, o_product
    );

    modport slave (
        input  i_start, i_multiplicand, i_multiplier, i_addend,
        output o_busy, o_done, o_product
    );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiply-accumulate: o_product = A*B + C, one iteration per multiplier bit.
// Fixed latency of D_WIDTH+1 edges from start to done; i_start in any state reloads and restarts.
module seq_multiplier #(
    parameter int D_WIDTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    seq_multiplier_if.slave    bus
);
    localparam int CNT_W = (D_WIDTH > 2) ? $clog2(D_WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_count;
    logic [D_WIDTH-1:0]     r_a;
    logic [D_WIDTH-1:0]     r_hi;
    logic [D_WIDTH-1:0]     r_lo;
    logic [2*D_WIDTH-1:0]   r_product;
    logic [D_WIDTH:0]       w_sum;
    logic                   w_last;

    assign w_last = (r_count == CNT_W'(D_WIDTH - 1));

    // The adder is one bit wider than hi so the carry-out shifts into hi's MSB.
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        bus.o_busy   = 1'b0;
        bus.o_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) w_next_state = ST_BUSY;
            end
            ST_BUSY: begin
                bus.o_busy = 1'b1;
                if (bus.i_start)  w_next_state = ST_BUSY;
                else if (w_last)  w_next_state = ST_DONE;
            end
            ST_DONE: begin
                bus.o_done = 1'b1;
                if (bus.i_start) w_next_state = ST_BUSY;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_count   <= '0;
            r_a       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_product <= '0;
        end else if (bus.i_start) begin
            r_count <= '0;
            r_a     <= bus.i_multiplicand;
            r_hi    <= bus.i_addend;
            r_lo    <= bus.i_multiplier;
        end else if (r_state == ST_BUSY) begin
            r_count <= r_count + CNT_W'(1);
            r_hi    <= w_sum[D_WIDTH:1];
            r_lo    <= {w_sum[0], r_lo[D_WIDTH-1:1]};
            // Only the final shifted accumulator is published; intermediates stay internal.
            if (w_last) r_product <= {w_sum, r_lo[D_WIDTH-1:1]};
        end
    end

    assign bus.o_product = r_product;
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed cases, restart, async reset,
// exhaustive D_WIDTH=4 sweep and random D_WIDTH=16 operations, scoreboard-based.
module tb_seq_multiplier;
    localparam int D   = 4;
    localparam int D16 = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    seq_multiplier_if #(.D_WIDTH(D))   m4 ();
    seq_multiplier_if #(.D_WIDTH(D16)) m16 ();

    seq_multiplier #(.D_WIDTH(D)) dut4 (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (m4.slave)
    );

    seq_multiplier #(.D_WIDTH(D16)) dut16 (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (m16.slave)
    );

    always #5 clk = ~clk;

    logic [7:0]  sb[$];
    logic [7:0]  last;
    logic [31:0] sb16[$];
    logic [31:0] last16;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] st4();
        return 64'({m4.o_busy, m4.o_done, m4.o_product});
    endfunction

    function automatic logic [63:0] st16();
        return 64'({m16.o_busy, m16.o_done, m16.o_product});
    endfunction

    // Called at a negedge; leaves the bench at the negedge after the start edge.
    task automatic drive_start(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        m4.i_start        = 1'b1;
        m4.i_multiplicand = a;
        m4.i_multiplier   = b;
        m4.i_addend       = c;
        sb.push_back(8'(a) * 8'(b) + 8'(c));
        @(posedge clk);
        @(negedge clk);
        m4.i_start        = 1'b0;
        m4.i_multiplicand = 4'($urandom);
        m4.i_multiplier   = 4'($urandom);
        m4.i_addend       = 4'($urandom);
        check("after_start", st4(), 64'({2'b10, last}));
    endtask

    task automatic iterate(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check("busy_hold", st4(), 64'({2'b10, last}));
        end
    endtask

    task automatic complete(input string tag);
        logic [7:0] exp;
        @(posedge clk);
        @(negedge clk);
        check("scoreboard_depth", 64'(sb.size()), 64'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        last = exp;
        check(tag, st4(), 64'({2'b01, exp}));
    endtask

    task automatic op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input string tag);
        drive_start(a, b, c);
        iterate(D - 1);
        complete(tag);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        logic [31:0] exp;
        m16.i_start        = 1'b1;
        m16.i_multiplicand = a;
        m16.i_multiplier   = b;
        m16.i_addend       = c;
        sb16.push_back(32'(a) * 32'(b) + 32'(c));
        @(posedge clk);
        @(negedge clk);
        m16.i_start = 1'b0;
        check("d16_after_start", st16(), 64'({2'b10, last16}));
        repeat (D16 - 1) begin
            @(posedge clk);
            @(negedge clk);
            check("d16_busy_hold", st16(), 64'({2'b10, last16}));
        end
        @(posedge clk);
        @(negedge clk);
        check("d16_scoreboard_depth", 64'(sb16.size()), 64'd1);
        exp = (sb16.size() > 0) ? sb16.pop_front() : 32'hxxxx_xxxx;
        last16 = exp;
        check("d16_result", st16(), 64'({2'b01, exp}));
    endtask

    initial begin
        m4.i_start = 1'b0;  m4.i_multiplicand = '0;  m4.i_multiplier = '0;  m4.i_addend = '0;
        m16.i_start = 1'b0; m16.i_multiplicand = '0; m16.i_multiplier = '0; m16.i_addend = '0;
        last   = '0;
        last16 = '0;

        #2;
        check("reset_state", st4(), 64'd0);
        check("d16_reset_state", st16(), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle_after_reset", st4(), 64'd0);

        op(4'd15, 4'd15, 4'd15, "max_operands");
        op(4'd3,  4'd4,  4'd1,  "divider_inverse_13");
        op(4'd13, 4'd11, 4'd2,  "divider_inverse_145");
        op(4'd0,  4'd9,  4'd7,  "zero_multiplicand");

        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("done_level_held", st4(), 64'({2'b01, last}));
        end

        // Restart two edges into an operation: the abandoned result must never appear.
        drive_start(4'd2, 4'd3, 4'd0);
        iterate(2);
        sb.delete();
        drive_start(4'd5, 4'd5, 4'd1);
        iterate(D - 1);
        complete("restart_result");

        // Start held high for three edges: only the last operands count.
        m4.i_start = 1'b1; m4.i_multiplicand = 4'd1; m4.i_multiplier = 4'd1; m4.i_addend = 4'd1;
        @(posedge clk);
        @(negedge clk);
        m4.i_multiplicand = 4'd9; m4.i_multiplier = 4'd2; m4.i_addend = 4'd0;
        @(posedge clk);
        @(negedge clk);
        check("held_start_busy", st4(), 64'({2'b10, last}));
        drive_start(4'd6, 4'd7, 4'd3);
        iterate(D - 1);
        complete("held_start_result");

        // Asynchronous reset between edges in the middle of an operation.
        drive_start(4'd9, 4'd9, 4'd9);
        iterate(2);
        #3 rstn = 1'b0;
        #1 check("async_reset_outputs", st4(), 64'd0);
        sb.delete();
        last = '0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_after_async_reset", st4(), 64'd0);
        end

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 16; c++)
                    op(4'(a), 4'(b), 4'(c), "exhaustive");

        op16(16'hFFFF, 16'hFFFF, 16'hFFFF);
        repeat (20) op16(16'($urandom), 16'($urandom), 16'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
